// File: rtl/aes_key_expand_seq_if.sv
// Handshake bundle between the AES-128 key-schedule engine and its round-key consumer.
interface aes_key_expand_seq_if;
  logic         start;
  logic [127:0] key_in;
  logic         key_ready;
  logic         key_valid;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         busy;
  logic         done;

  modport master (
    output start, key_in, key_ready,
    input  key_valid, round_key, round_idx, busy, done
  );

  modport slave (
    input  start, key_in, key_ready,
    output key_valid, round_key, round_idx, busy, done
  );
endinterface

// File: rtl/aes_key_expand_seq.sv
// Iterative AES-128 key expansion: emits round keys 0..10 one at a time on a
// valid/ready handshake, computing each next key in a single CALC cycle.
module aes_key_expand_seq (
  input  logic                clk,
  input  logic                rst,
  aes_key_expand_seq_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_OUT, S_CALC} state_t;

  // FIPS-197 forward S-box, entry 0x00 in the top byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    // Entry x sits at bit offset 8*(255-x), and 255-x is simply ~x.
    return SBOX_TBL[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  state_t       r_state;
  state_t       w_next;
  logic [127:0] r_key;
  logic [3:0]   r_idx;
  logic [7:0]   r_rcon;
  logic         r_done;

  logic         w_hs;
  logic [31:0]  w_rot;
  logic [31:0]  w_temp;
  logic [31:0]  w_w0n;
  logic [31:0]  w_w1n;
  logic [31:0]  w_w2n;
  logic [31:0]  w_w3n;

  assign w_hs = (r_state == S_OUT) && bus.key_ready;

  assign w_rot  = {r_key[23:0], r_key[31:24]};
  assign w_temp = {sbox(w_rot[31:24]) ^ r_rcon, sbox(w_rot[23:16]),
                   sbox(w_rot[15:8]), sbox(w_rot[7:0])};
  assign w_w0n  = r_key[127:96] ^ w_temp;
  assign w_w1n  = r_key[95:64]  ^ w_w0n;
  assign w_w2n  = r_key[63:32]  ^ w_w1n;
  assign w_w3n  = r_key[31:0]   ^ w_w2n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (bus.start) w_next = S_OUT;
      S_OUT:  if (w_hs)      w_next = (r_idx == 4'd10) ? S_IDLE : S_CALC;
      S_CALC:                w_next = S_OUT;
      default:               w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key  <= '0;
      r_idx  <= '0;
      r_rcon <= 8'h01;
      r_done <= 1'b0;
    end else begin
      r_done <= w_hs && (r_idx == 4'd10);
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_key  <= bus.key_in;
          r_idx  <= 4'd0;
          r_rcon <= 8'h01;
        end
        S_CALC: begin
          r_key  <= {w_w0n, w_w1n, w_w2n, w_w3n};
          r_idx  <= r_idx + 4'd1;
          r_rcon <= xtime(r_rcon);
        end
        default: ;
      endcase
    end
  end

  assign bus.key_valid = (r_state == S_OUT);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = r_done;
  assign bus.round_key = r_key;
  assign bus.round_idx = r_idx;

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Scoreboard bench for aes_key_expand_seq: directed FIPS-197 vectors, back-pressure,
// ignored start, mid-expansion reset and back-to-back expansions.
module tb_aes_key_expand_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_key_expand_seq_if bus();

  aes_key_expand_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] key;
    logic         chk;
  } exp_t;

  localparam logic [127:0] A1 [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };
  localparam logic [127:0] Z1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   hs_cnt   = 0;
  int   done_cnt = 0;
  exp_t sb[$];

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a1();
    for (int i = 0; i < 11; i++) sb.push_back('{idx: 4'(i), key: A1[i], chk: 1'b1});
  endtask

  task automatic push_zero();
    logic [127:0] k;
    for (int i = 0; i < 11; i++) begin
      k = (i == 1) ? Z1 : (i == 10) ? Z10 : 128'h0;
      sb.push_back('{idx: 4'(i), key: k, chk: (i == 0 || i == 1 || i == 10)});
    end
  endtask

  task automatic wait_done(input int bound, input string name);
    int k;
    k = 0;
    while (!bus.done && k < bound) begin
      tick();
      k++;
    end
    chk(name, 128'(bus.done), 128'(1));
  endtask

  // Monitor: pops the scoreboard on every handshake and checks hold-under-stall.
  logic         prev_stall = 1'b0;
  logic [127:0] prev_key;
  logic [3:0]   prev_idx;
  exp_t         e;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 128'(bus.key_valid), 128'(1));
        chk("hold_key", bus.round_key, prev_key);
        chk("hold_idx", 128'(bus.round_idx), 128'(prev_idx));
      end
      if (bus.done) done_cnt++;
      if (bus.key_valid && bus.key_ready) begin
        hs_cnt++;
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_handshake: got idx %0d key %h, expected none", bus.round_idx, bus.round_key);
        end else begin
          e = sb.pop_front();
          chk("sb_idx", 128'(bus.round_idx), 128'(e.idx));
          if (e.chk) chk("sb_key", bus.round_key, e.key);
        end
      end
      prev_stall = bus.key_valid && !bus.key_ready;
      prev_key   = bus.round_key;
      prev_idx   = bus.round_idx;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int h0;
    int d0;
    int k;
    bus.start     = 1'b0;
    bus.key_in    = '0;
    bus.key_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 128'(bus.key_valid), 128'(0));
    chk("rst_busy",  128'(bus.busy), 128'(0));
    chk("rst_done",  128'(bus.done), 128'(0));
    chk("rst_key",   bus.round_key, 128'h0);
    chk("rst_idx",   128'(bus.round_idx), 128'(0));
    rst = 1'b0;
    tick();

    // A.1 vector with cycle-exact timing
    bus.key_ready = 1'b1;
    bus.key_in    = A1[0];
    bus.start     = 1'b1;
    push_a1();
    for (int c = 1; c <= 22; c++) begin
      tick();
      if (c == 1) begin
        bus.start  = 1'b0;
        bus.key_in = ~A1[0];
      end
      chk("t1_valid", 128'(bus.key_valid), 128'(c < 22 && (c % 2) == 1));
      chk("t1_done",  128'(bus.done), 128'(c == 22));
      chk("t1_busy",  128'(bus.busy), 128'(c < 22));
    end
    chk("t1_sb_empty", 128'(sb.size()), 128'(0));

    // All-zero key, then a new start exactly in the done cycle
    tick();
    bus.key_in = '0;
    bus.start  = 1'b1;
    push_zero();
    tick();
    bus.start  = 1'b0;
    bus.key_in = '1;
    wait_done(30, "t2_done");
    bus.key_in = A1[0];
    bus.start  = 1'b1;
    push_a1();
    tick();
    bus.start = 1'b0;
    chk("t2_b2b_valid", 128'(bus.key_valid), 128'(1));
    chk("t2_b2b_idx",   128'(bus.round_idx), 128'(0));
    chk("t2_b2b_key",   bus.round_key, A1[0]);
    wait_done(30, "t2b_done");
    chk("t2_sb_empty", 128'(sb.size()), 128'(0));

    // Random back-pressure
    tick();
    h0 = hs_cnt;
    bus.key_ready = 1'b0;
    bus.key_in    = A1[0];
    bus.start     = 1'b1;
    push_a1();
    tick();
    bus.start = 1'b0;
    k = 0;
    while (!bus.done && k < 400) begin
      bus.key_ready = 1'($urandom_range(0, 1));
      tick();
      k++;
    end
    chk("t3_done", 128'(bus.done), 128'(1));
    chk("t3_hs_count", 128'(hs_cnt - h0), 128'(11));
    chk("t3_sb_empty", 128'(sb.size()), 128'(0));
    bus.key_ready = 1'b1;

    // start pulses with a different key while busy are ignored
    tick();
    h0 = hs_cnt;
    bus.key_in = A1[0];
    bus.start  = 1'b1;
    push_a1();
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    bus.key_in = '0;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    bus.key_in = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    repeat (4) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(40, "t4_done");
    chk("t4_hs_count", 128'(hs_cnt - h0), 128'(11));
    chk("t4_sb_empty", 128'(sb.size()), 128'(0));

    // Reset while round key 5 is presented
    tick();
    d0 = done_cnt;
    bus.key_in = A1[0];
    bus.start  = 1'b1;
    push_a1();
    tick();
    bus.start = 1'b0;
    k = 0;
    while (!(bus.key_valid && bus.round_idx == 4'd5) && k < 40) begin
      tick();
      k++;
    end
    chk("t5_reach_idx5", 128'(bus.round_idx), 128'(5));
    rst = 1'b1;
    #1;
    chk("t5_valid", 128'(bus.key_valid), 128'(0));
    chk("t5_busy",  128'(bus.busy), 128'(0));
    chk("t5_key",   bus.round_key, 128'h0);
    chk("t5_done",  128'(bus.done), 128'(0));
    chk("t5_idx",   128'(bus.round_idx), 128'(0));
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (30) tick();
    chk("t5_no_done", 128'(done_cnt - d0), 128'(0));
    chk("t5_idle_valid", 128'(bus.key_valid), 128'(0));
    bus.key_in = A1[0];
    bus.start  = 1'b1;
    push_a1();
    tick();
    bus.start = 1'b0;
    wait_done(30, "t5_restart_done");
    chk("t5_sb_empty", 128'(sb.size()), 128'(0));

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
